// File: rtl/array_19_arb.sv
// array_19_arb: read/write arbiter with starvation bound for a 4096x60 lane-masked SRAM; ARRAY19_ARB_INIT_EN adds a zero-fill sweep
module array_19_arb #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 60,
  parameter int LANES = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_resp_valid,
  output logic [DATA_W-1:0] rd_resp_data,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [LANES-1:0]  wr_req_mask,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              init_done
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] starve_cnt;
  logic [ADDR_W-1:0] init_ptr;
  logic sweep;
  logic wr_win;
`ifdef ARRAY19_ARB_INIT_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t state;
  // zero-fill sweep over every address, then one settling cycle before serving traffic
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= INIT;
      init_ptr <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= state == RUN;
      if (state == INIT) begin
        init_ptr <= init_ptr + 1'b1;
        if (init_ptr == '1) state <= RUN;
      end
    end
  end
  assign sweep = reset_n && state == INIT;
`else
  // serving starts on the first edge after reset release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) init_done <= 1'b0;
    else init_done <= 1'b1;
  end
  assign init_ptr = '0;
  assign sweep = 1'b0;
`endif
  // reads win ties until the pending write has waited STARVE_LIMIT cycles
  always_comb begin
    wr_win = wr_req_valid && (!rd_req_valid || starve_cnt >= LIM);
    rd_req_ready = init_done && rd_req_valid && !wr_win;
    wr_req_ready = init_done && wr_win;
    sram_en = sweep || rd_req_ready || wr_req_ready;
    sram_wmode = sweep || wr_req_ready;
    sram_addr = sweep ? init_ptr : wr_req_ready ? wr_req_addr : rd_req_ready ? rd_req_addr : '0;
    sram_wmask = sweep ? '1 : wr_req_ready ? wr_req_mask : '0;
    sram_wdata = wr_req_ready ? wr_req_data : '0;
  end
  // response strobe follows the read handshake; starvation counter saturates while a write is held off
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_resp_valid <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rd_resp_valid <= rd_req_ready;
      starve_cnt <= (!init_done || !wr_req_valid || wr_req_ready) ? '0 :
                    starve_cnt == LIM ? LIM : starve_cnt + 1'b1;
    end
  end
  assign rd_resp_data = sram_rdata;
endmodule
